// File: rtl/majority_vote_pkg.sv
// Shared types, limits and voting helpers for the N-modular-redundant voting register.
package majority_vote_pkg;

  // Health state of one replica.
  typedef enum logic [1:0] {
    CS_OK      = 2'b00,
    CS_SUSPECT = 2'b01,
    CS_FAILED  = 2'b10
  } copy_state_e;

  // Largest replica count supported; vote columns are zero-padded to this width.
  localparam int unsigned MAX_N = 7;

  // Width of the per-copy consecutive-mismatch counter (covers thresholds up to 255).
  localparam int unsigned HCNT_W = 8;

  // Number of set bits in a padded replica column.
  function automatic logic [3:0] popcount(input logic [MAX_N-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Majority of one bit column over the healthy copies. A tie resolves to the
  // lowest-index healthy copy; with no healthy copy the result is copy 0.
  function automatic logic vote_bit(input logic [MAX_N-1:0] bits,
                                    input logic [MAX_N-1:0] healthy);
    logic [4:0] ones_x2;
    logic [4:0] n_healthy;
    logic       tie_bit;
    logic       found;
    ones_x2   = {popcount(bits & healthy), 1'b0};
    n_healthy = {1'b0, popcount(healthy)};
    tie_bit   = bits[0];
    found     = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (!found && healthy[i]) begin
        tie_bit = bits[i];
        found   = 1'b1;
      end
    end
    if (n_healthy == 5'd0) begin
      return bits[0];
    end else if (ones_x2 > n_healthy) begin
      return 1'b1;
    end else if (ones_x2 < n_healthy) begin
      return 1'b0;
    end else begin
      return tie_bit;
    end
  endfunction

endpackage

// File: rtl/majority_vote_reg_copy_health_fsm.sv
// Health tracker for a single replica: counts consecutive mismatching valid
// samples and latches a sticky failure once the threshold is reached.
module copy_health_fsm
  import majority_vote_pkg::*;
#(
  parameter int unsigned FAIL_THRESH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic valid_i,
  input  logic mismatch_i,
  output logic failed_o
);

  if (FAIL_THRESH < 1 || FAIL_THRESH > 255) begin : g_bad_thresh
    $error("copy_health_fsm: FAIL_THRESH must be in 1..255");
  end

  localparam logic [HCNT_W-1:0] THRESH = HCNT_W'(FAIL_THRESH);

  copy_state_e        state_r;
  copy_state_e        state_s;
  logic [HCNT_W-1:0]  cnt_r;
  logic [HCNT_W-1:0]  cnt_s;
  logic [HCNT_W-1:0]  cnt_inc_s;
  logic               failed_r;

  // Next-state and counter logic; clear overrides any effect of a same-cycle sample.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    cnt_inc_s = cnt_r + 8'd1;
    if (clear_i) begin
      state_s = CS_OK;
      cnt_s   = 8'd0;
    end else if (valid_i) begin
      case (state_r)
        CS_OK: begin
          if (mismatch_i) begin
            cnt_s   = 8'd1;
            state_s = (THRESH <= 8'd1) ? CS_FAILED : CS_SUSPECT;
          end else begin
            cnt_s   = 8'd0;
            state_s = CS_OK;
          end
        end
        CS_SUSPECT: begin
          if (mismatch_i) begin
            cnt_s   = cnt_inc_s;
            state_s = (cnt_inc_s >= THRESH) ? CS_FAILED : CS_SUSPECT;
          end else begin
            cnt_s   = 8'd0;
            state_s = CS_OK;
          end
        end
        CS_FAILED: begin
          state_s = CS_FAILED;
          cnt_s   = cnt_r;
        end
        default: begin
          state_s = CS_OK;
          cnt_s   = 8'd0;
        end
      endcase
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  // State, counter and registered failure flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= CS_OK;
      cnt_r    <= 8'd0;
      failed_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      failed_r <= (state_s == CS_FAILED);
    end
  end

  assign failed_o = failed_r;

endmodule

// File: rtl/majority_vote_reg.sv
// N-modular-redundant voting register: registers the bitwise majority of the
// healthy replicas, reports per-copy disagreement and excludes copies that
// disagree persistently.
module majority_vote_reg
  import majority_vote_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned N           = 3,
  parameter int unsigned FAIL_THRESH = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [N*WIDTH-1:0]   x_i,
  input  logic                 clear_i,
  output logic [WIDTH-1:0]     y_o,
  output logic                 valid_o,
  output logic [N-1:0]         mismatch_o,
  output logic [N-1:0]         failed_o,
  output logic                 no_quorum_o,
  output logic [CNT_W-1:0]     err_cnt_o
);

  if ((N % 2) == 0 || N < 3 || N > MAX_N) begin : g_bad_n
    $error("majority_vote_reg: N must be odd and in 3..7");
  end
  if (FAIL_THRESH < 1) begin : g_bad_thresh
    $error("majority_vote_reg: FAIL_THRESH must be at least 1");
  end

  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  logic [N-1:0]       failed_s;
  logic [MAX_N-1:0]   healthy_s;
  logic [MAX_N-1:0]   col_s;
  logic [WIDTH-1:0]   vote_s;
  logic [N-1:0]       mismatch_s;
  logic               no_quorum_s;

  logic [WIDTH-1:0]   y_r;
  logic               valid_r;
  logic [N-1:0]       mismatch_r;
  logic               no_quorum_r;
  logic [CNT_W-1:0]   err_cnt_r;

  // Combinational vote over the copies that are healthy in the current cycle.
  always_comb begin
    healthy_s = {MAX_N{1'b0}};
    col_s     = {MAX_N{1'b0}};
    vote_s    = {WIDTH{1'b0}};
    for (int k = 0; k < N; k++) begin
      healthy_s[k] = ~failed_s[k];
    end
    for (int w = 0; w < WIDTH; w++) begin
      col_s = {MAX_N{1'b0}};
      for (int k = 0; k < N; k++) begin
        col_s[k] = x_i[k*WIDTH + w];
      end
      vote_s[w] = vote_bit(col_s, healthy_s);
    end
    no_quorum_s = &failed_s;
  end

  // Every copy, failed or not, is compared against the vote.
  always_comb begin
    mismatch_s = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      mismatch_s[k] = |(x_i[k*WIDTH +: WIDTH] ^ vote_s);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_copy
    copy_health_fsm #(
      .FAIL_THRESH (FAIL_THRESH)
    ) u_health (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .valid_i    (valid_i),
      .mismatch_i (mismatch_s[k]),
      .failed_o   (failed_s[k])
    );
  end

  // Voted result and per-sample status; held while no sample arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_r         <= {WIDTH{1'b0}};
      valid_r     <= 1'b0;
      mismatch_r  <= {N{1'b0}};
      no_quorum_r <= 1'b0;
    end else if (valid_i) begin
      y_r         <= vote_s;
      valid_r     <= 1'b1;
      mismatch_r  <= mismatch_s;
      no_quorum_r <= no_quorum_s;
    end else begin
      valid_r     <= 1'b0;
    end
  end

  // Saturating count of samples where any copy disagreed; clear wins over counting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (valid_i && (|mismatch_s) && (err_cnt_r != ERR_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign y_o         = y_r;
  assign valid_o     = valid_r;
  assign mismatch_o  = mismatch_r;
  assign failed_o    = failed_s;
  assign no_quorum_o = no_quorum_r;
  assign err_cnt_o   = err_cnt_r;

endmodule

// File: tb/tb_majority_vote_reg.sv
// Scoreboard bench for majority_vote_reg with WIDTH=4, N=3, FAIL_THRESH=3, CNT_W=2.
module tb_majority_vote_reg;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int FT = 3;
  localparam int CW = 2;

  typedef struct packed {
    logic [3:0] y;
    logic [2:0] mm;
    logic [2:0] fail;
    logic       nq;
    logic [1:0] err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_i;
  logic [N*W-1:0]  x_i;
  logic            clear_i;
  logic [W-1:0]    y_o;
  logic            valid_o;
  logic [N-1:0]    mismatch_o;
  logic [N-1:0]    failed_o;
  logic            no_quorum_o;
  logic [CW-1:0]   err_cnt_o;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  majority_vote_reg #(
    .WIDTH(W), .N(N), .FAIL_THRESH(FT), .CNT_W(CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid_i),
    .x_i         (x_i),
    .clear_i     (clear_i),
    .y_o         (y_o),
    .valid_o     (valid_o),
    .mismatch_o  (mismatch_o),
    .failed_o    (failed_o),
    .no_quorum_o (no_quorum_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per presented output sample.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 expected=0 at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("y_o",         32'(y_o),         32'(mon_e.y));
        chk("mismatch_o",  32'(mismatch_o),  32'(mon_e.mm));
        chk("failed_o",    32'(failed_o),    32'(mon_e.fail));
        chk("no_quorum_o", 32'(no_quorum_o), 32'(mon_e.nq));
        chk("err_cnt_o",   32'(err_cnt_o),   32'(mon_e.err));
      end
    end
  end

  // Issue one valid sample and record what it must produce.
  task automatic sample(input logic [11:0] x, input logic clr, input logic [3:0] ey,
                        input logic [2:0] emm, input logic [2:0] efail,
                        input logic enq, input logic [1:0] eerr);
    exp_t e;
    e.y = ey; e.mm = emm; e.fail = efail; e.nq = enq; e.err = eerr;
    sb_q.push_back(e);
    x_i     = x;
    valid_i = 1'b1;
    clear_i = clr;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  // Clear without a sample: health and counter reset, output value held.
  task automatic idle_clear(input logic [3:0] hold_y);
    clear_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    chk("clear_failed",  32'(failed_o),  32'd0);
    chk("clear_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("idle_valid_o",  32'(valid_o),   32'd0);
    chk("idle_y_hold",   32'(y_o),       32'(hold_y));
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b1;
    clear_i = 1'b0;
    x_i     = 12'hAAA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y",      32'(y_o),         32'd0);
    chk("rst_valid",  32'(valid_o),     32'd0);
    chk("rst_mm",     32'(mismatch_o),  32'd0);
    chk("rst_failed", 32'(failed_o),    32'd0);
    chk("rst_nq",     32'(no_quorum_o), 32'd0);
    chk("rst_err",    32'(err_cnt_o),   32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic agreement, single outvoted copy, copy 2 failing after three mismatches.
    sample(12'hAAA, 1'b0, 4'hA, 3'b000, 3'b000, 1'b0, 2'd0);
    sample(12'hA5A, 1'b0, 4'hA, 3'b010, 3'b000, 1'b0, 2'd1);
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b000, 1'b0, 2'd2);
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b000, 1'b0, 2'd3);
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b100, 1'b0, 2'd3);
    idle_clear(4'hA);

    // A matching sample after two mismatches resets the streak.
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b000, 1'b0, 2'd1);
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b000, 1'b0, 2'd2);
    sample(12'hAAA, 1'b0, 4'hA, 3'b000, 3'b000, 1'b0, 2'd2);
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b000, 1'b0, 2'd3);
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b000, 1'b0, 2'd3);
    sample(12'hFAA, 1'b0, 4'hA, 3'b100, 3'b100, 1'b0, 2'd3);

    // Two healthy copies tie on every bit: copy 0 wins, copy 1 eventually fails.
    sample(12'hA5A, 1'b0, 4'hA, 3'b010, 3'b100, 1'b0, 2'd3);
    sample(12'hA5A, 1'b0, 4'hA, 3'b010, 3'b100, 1'b0, 2'd3);
    sample(12'hA5A, 1'b0, 4'hA, 3'b010, 3'b110, 1'b0, 2'd3);

    // Copy 0 alone decides.
    sample(12'h55A, 1'b0, 4'hA, 3'b110, 3'b110, 1'b0, 2'd3);
    sample(12'h33C, 1'b0, 4'hC, 3'b110, 3'b110, 1'b0, 2'd3);
    idle_clear(4'hC);

    // {6,5,3} votes to 7, disagreeing with every copy: all three fail together.
    sample(12'h653, 1'b0, 4'h7, 3'b111, 3'b000, 1'b0, 2'd1);
    sample(12'h653, 1'b0, 4'h7, 3'b111, 3'b000, 1'b0, 2'd2);
    sample(12'h653, 1'b0, 4'h7, 3'b111, 3'b111, 1'b0, 2'd3);

    // No quorum: copy 0 passes through; clear with valid votes with the old mask.
    sample(12'h37C, 1'b0, 4'hC, 3'b110, 3'b111, 1'b1, 2'd3);
    sample(12'h37C, 1'b1, 4'hC, 3'b110, 3'b000, 1'b1, 2'd0);
    sample(12'h37C, 1'b0, 4'h7, 3'b101, 3'b000, 1'b0, 2'd1);
    idle_clear(4'h7);

    // Error counter saturates at 3 over five mismatching samples.
    sample(12'hAA5, 1'b0, 4'hA, 3'b001, 3'b000, 1'b0, 2'd1);
    sample(12'hAA5, 1'b0, 4'hA, 3'b001, 3'b000, 1'b0, 2'd2);
    sample(12'hAA5, 1'b0, 4'hA, 3'b001, 3'b001, 1'b0, 2'd3);
    sample(12'hAA5, 1'b0, 4'hA, 3'b001, 3'b001, 1'b0, 2'd3);
    sample(12'hAA5, 1'b0, 4'hA, 3'b001, 3'b001, 1'b0, 2'd3);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_y",      32'(y_o),         32'd0);
    chk("arst_valid",  32'(valid_o),     32'd0);
    chk("arst_mm",     32'(mismatch_o),  32'd0);
    chk("arst_failed", 32'(failed_o),    32'd0);
    chk("arst_nq",     32'(no_quorum_o), 32'd0);
    chk("arst_err",    32'(err_cnt_o),   32'd0);
    chk("sb_drained",  32'(sb_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
